// File: rtl/jt053246_draw.sv
// Sprite line drawer: fetches one 16-pixel row of a 4bpp tile, applies h-zoom/flip, writes opaque pixels to the line buffer.
// Optional shadow marking is enabled with `define JT053246_DRAW_SHADOW_EN.
module jt053246_draw #(
    parameter int unsigned BW     = 9,
    parameter int unsigned HZ_ONE = 64,
    parameter int unsigned MAXPX  = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          dr_start,
    output logic          dr_busy,
    input  logic [15:0]   code,
    input  logic [9:0]    attr,
    input  logic          hflip,
    input  logic          vflip,
    input  logic [8:0]    hpos,
    input  logic [3:0]    ysub,
    input  logic [9:0]    hzoom,
    input  logic          hz_keep,
`ifdef JT053246_DRAW_SHADOW_EN
    input  logic [1:0]    shd,
`endif
    output logic [20:0]   rom_addr,
    output logic          rom_cs,
    input  logic          rom_ok,
    input  logic [31:0]   rom_data,
    output logic [BW-1:0] buf_addr,
`ifdef JT053246_DRAW_SHADOW_EN
    output logic [15:0]   buf_din,
`else
    output logic [13:0]   buf_din,
`endif
    output logic          buf_we
);

    localparam int unsigned AW = 11;
    localparam int unsigned CW = $clog2(MAXPX + 1);
`ifdef JT053246_DRAW_SHADOW_EN
    localparam int unsigned DW = 16;
`else
    localparam int unsigned DW = 14;
`endif
    localparam logic [AW-1:0] ACC_END = AW'(16 << 6);

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH0, ST_FETCH1, ST_DRAW} state_t;

    state_t          r_state;
    state_t          w_state_nx;

    logic [15:0]     r_code;
    logic [3:0]      r_row;
    logic [9:0]      r_attr;
    logic            r_hflip;
    logic [9:0]      r_step;
    logic [63:0]     r_pix;
    logic [BW-1:0]   r_pos;
    logic [AW-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;
`ifdef JT053246_DRAW_SHADOW_EN
    logic [1:0]      r_shd;
`endif

    logic            r_busy;
    logic            r_rom_cs;
    logic [20:0]     r_rom_addr;
    logic [BW-1:0]   r_buf_addr;
    logic [DW-1:0]   r_buf_din;
    logic            r_buf_we;

    logic [3:0]      w_row_in;
    logic [9:0]      w_step_in;
    logic [AW-1:0]   w_acc_keep;
    logic [3:0]      w_src;
    logic [3:0]      w_col;
    logic [5:0]      w_sh;
    logic [3:0]      w_pen;
    logic [AW-1:0]   w_acc_sum;
    logic            w_last;

    logic            w_busy_nx;
    logic            w_rom_cs_nx;
    logic [20:0]     w_rom_addr_nx;
    logic [BW-1:0]   w_buf_addr_nx;
    logic [DW-1:0]   w_buf_din_nx;
    logic            w_buf_we_nx;

    assign dr_busy  = r_busy;
    assign rom_cs   = r_rom_cs;
    assign rom_addr = r_rom_addr;
    assign buf_addr = r_buf_addr;
    assign buf_din  = r_buf_din;
    assign buf_we   = r_buf_we;

    // Tile-start helpers and per-pixel source selection
    always_comb begin
        w_row_in   = ysub ^ {4{vflip}};
        w_step_in  = (hzoom == 10'd0) ? 10'(HZ_ONE) : hzoom;
        w_acc_keep = r_acc[10] ? {1'b0, r_acc[9:0]} : '0;
        w_src      = r_acc[9:6];
        w_col      = r_hflip ? ~w_src : w_src;
        w_sh       = {~w_col, 2'b00};
        w_pen      = r_pix[w_sh +: 4];
        w_acc_sum  = r_acc + AW'(r_step);
        w_last     = (w_acc_sum >= ACC_END) || (r_cnt == CW'(MAXPX - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (cen) begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:   if (dr_start) w_state_nx = ST_FETCH0;
            ST_FETCH0: if (rom_ok)   w_state_nx = ST_FETCH1;
            ST_FETCH1: if (rom_ok)   w_state_nx = ST_DRAW;
            ST_DRAW:   if (w_last)   w_state_nx = ST_IDLE;
            default:                 w_state_nx = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        w_busy_nx     = r_busy;
        w_rom_cs_nx   = r_rom_cs;
        w_rom_addr_nx = r_rom_addr;
        w_buf_addr_nx = r_buf_addr;
        w_buf_din_nx  = r_buf_din;
        w_buf_we_nx   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (dr_start) begin
                    w_busy_nx     = 1'b1;
                    w_rom_cs_nx   = 1'b1;
                    w_rom_addr_nx = {code, w_row_in, 1'b0};
                end
            end
            ST_FETCH0: begin
                if (rom_ok) w_rom_addr_nx = {r_code, r_row, 1'b1};
            end
            ST_FETCH1: begin
                if (rom_ok) w_rom_cs_nx = 1'b0;
            end
            ST_DRAW: begin
                w_buf_we_nx   = (w_pen != 4'd0);
                w_buf_addr_nx = r_pos;
`ifdef JT053246_DRAW_SHADOW_EN
                // Pen 15 on a shadowed sprite is a marker, not a colour
                w_buf_din_nx  = (w_pen == 4'hF && r_shd != 2'd0) ?
                                {r_shd, 10'd0, w_pen} : {r_shd, r_attr, w_pen};
`else
                w_buf_din_nx  = {r_attr, w_pen};
`endif
                if (w_last) w_busy_nx = 1'b0;
            end
            default: begin
                w_busy_nx   = 1'b0;
                w_rom_cs_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy     <= 1'b0;
            r_rom_cs   <= 1'b0;
            r_rom_addr <= '0;
            r_buf_addr <= '0;
            r_buf_din  <= '0;
            r_buf_we   <= 1'b0;
            r_code     <= '0;
            r_row      <= '0;
            r_attr     <= '0;
            r_hflip    <= 1'b0;
            r_step     <= '0;
            r_pix      <= '0;
            r_pos      <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
`ifdef JT053246_DRAW_SHADOW_EN
            r_shd      <= '0;
`endif
        end else if (cen) begin
            r_busy     <= w_busy_nx;
            r_rom_cs   <= w_rom_cs_nx;
            r_rom_addr <= w_rom_addr_nx;
            r_buf_addr <= w_buf_addr_nx;
            r_buf_din  <= w_buf_din_nx;
            r_buf_we   <= w_buf_we_nx;
            case (r_state)
                ST_IDLE: begin
                    if (dr_start) begin
                        r_code  <= code;
                        r_row   <= w_row_in;
                        r_attr  <= attr;
                        r_hflip <= hflip;
                        r_step  <= w_step_in;
                        r_cnt   <= '0;
`ifdef JT053246_DRAW_SHADOW_EN
                        r_shd   <= shd;
`endif
                        // Continuation keeps position and the fractional phase for seamless joins
                        r_pos   <= hz_keep ? r_pos : BW'(hpos);
                        r_acc   <= hz_keep ? w_acc_keep : '0;
                    end
                end
                ST_FETCH0: if (rom_ok) r_pix[63:32] <= rom_data;
                ST_FETCH1: if (rom_ok) r_pix[31:0]  <= rom_data;
                ST_DRAW: begin
                    r_pos <= r_pos + BW'(1);
                    r_acc <= w_acc_sum;
                    r_cnt <= r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jt053246_draw.sv
// Scoreboard bench for jt053246_draw: a line-drawing model queues expected buffer writes, a monitor pops them.
module tb_jt053246_draw;

    localparam int unsigned BW = 9;
`ifdef JT053246_DRAW_SHADOW_EN
    localparam int unsigned DW = 16;
`else
    localparam int unsigned DW = 14;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cen = 1'b1;
    logic          dr_start = 1'b0;
    logic          dr_busy;
    logic [15:0]   code = '0;
    logic [9:0]    attr = '0;
    logic          hflip = 1'b0;
    logic          vflip = 1'b0;
    logic [8:0]    hpos = '0;
    logic [3:0]    ysub = '0;
    logic [9:0]    hzoom = '0;
    logic          hz_keep = 1'b0;
`ifdef JT053246_DRAW_SHADOW_EN
    logic [1:0]    shd = '0;
`endif
    logic [20:0]   rom_addr;
    logic          rom_cs;
    logic          rom_ok;
    logic [31:0]   rom_data;
    logic [BW-1:0] buf_addr;
    logic [DW-1:0] buf_din;
    logic          buf_we;

    logic [31:0]   rom_w0 = '0;
    logic [31:0]   rom_w1 = '0;
    logic          rom_stall = 1'b0;

    assign rom_data = rom_addr[0] ? rom_w1 : rom_w0;
    assign rom_ok   = rom_cs & ~rom_stall;

    always #5 clk = ~clk;

    jt053246_draw dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .dr_start (dr_start),
        .dr_busy  (dr_busy),
        .code     (code),
        .attr     (attr),
        .hflip    (hflip),
        .vflip    (vflip),
        .hpos     (hpos),
        .ysub     (ysub),
        .hzoom    (hzoom),
        .hz_keep  (hz_keep),
`ifdef JT053246_DRAW_SHADOW_EN
        .shd      (shd),
`endif
        .rom_addr (rom_addr),
        .rom_cs   (rom_cs),
        .rom_ok   (rom_ok),
        .rom_data (rom_data),
        .buf_addr (buf_addr),
        .buf_din  (buf_din),
        .buf_we   (buf_we)
    );

    int errors = 0;
    int checks = 0;
    int n_writes = 0;
    int m_pos = 0;
    int m_acc = 0;
    logic [BW-1:0] q_addr[$];
    logic [DW-1:0] q_din[$];
    logic [BW-1:0] mon_ea;
    logic [DW-1:0] mon_ed;

    // Every buffer write must match the head of the expected queue
    always @(negedge clk) begin
        if (buf_we === 1'b1) begin
            n_writes++;
            checks++;
            if (q_addr.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h din=%h, expected no write", buf_addr, buf_din);
            end else begin
                mon_ea = q_addr.pop_front();
                mon_ed = q_din.pop_front();
                if (buf_addr !== mon_ea || buf_din !== mon_ed) begin
                    errors++;
                    $display("FAIL write: got addr=%h din=%h, expected addr=%h din=%h",
                             buf_addr, buf_din, mon_ea, mon_ed);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            tick();
            if (dr_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Line-drawing model: queues the writes one tile should produce
    task automatic push_tile(input logic [9:0] a, input logic hf, input logic [8:0] hp,
                             input logic [9:0] hz, input logic keep);
        int pos, acc, step, src, col, pen;
        pos  = keep ? m_pos : int'(hp);
        acc  = keep ? ((m_acc >= 1024) ? m_acc - 1024 : 0) : 0;
        step = (hz == 10'd0) ? 64 : int'(hz);
        for (int k = 0; k < 255; k++) begin
            src = acc / 64;
            col = hf ? 15 - src : src;
            pen = (col < 8) ? int'((rom_w0 >> (28 - 4 * col)) & 32'hF)
                            : int'((rom_w1 >> (28 - 4 * (col - 8))) & 32'hF);
            if (pen != 0) begin
                q_addr.push_back(BW'(pos));
                q_din.push_back(DW'({a, 4'(pen)}));
            end
            pos = (pos + 1) % 512;
            acc = acc + step;
            if (acc >= 1024) break;
        end
        m_pos = pos;
        m_acc = acc;
    endtask

    task automatic start_tile(input logic [15:0] c, input logic [9:0] a, input logic hf, input logic vf,
                              input logic [8:0] hp, input logic [3:0] ys, input logic [9:0] hz,
                              input logic keep);
        tick();
        code = c; attr = a; hflip = hf; vflip = vf; hpos = hp; ysub = ys; hzoom = hz; hz_keep = keep;
        dr_start = 1'b1;
        tick();
        dr_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (dr_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", dr_busy); end
        checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL reset_rom_cs: got %b, expected 0", rom_cs); end
        checks++; if (buf_we !== 1'b0) begin errors++; $display("FAIL reset_buf_we: got %b, expected 0", buf_we); end
        checks++; if (rom_addr !== 21'd0) begin errors++; $display("FAIL reset_rom_addr: got %h, expected 0", rom_addr); end
        checks++; if (buf_addr !== '0) begin errors++; $display("FAIL reset_buf_addr: got %h, expected 0", buf_addr); end
        checks++; if (buf_din !== '0) begin errors++; $display("FAIL reset_buf_din: got %h, expected 0", buf_din); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_zoom1();
        int n0;
        bit ok;
        rom_w0 = 32'h12345678; rom_w1 = 32'h9ABCDEF1; rom_stall = 1'b0;
        push_tile(10'h2A5, 1'b0, 9'h100, 10'd64, 1'b0);
        n0 = n_writes;
        start_tile(16'h1234, 10'h2A5, 1'b0, 1'b0, 9'h100, 4'd3, 10'd64, 1'b0);
        checks++; if (dr_busy !== 1'b1) begin errors++; $display("FAIL zoom1_busy_rise: got %b, expected 1", dr_busy); end
        checks++; if (rom_cs !== 1'b1 || rom_addr !== {16'h1234, 4'h3, 1'b0})
            begin errors++; $display("FAIL zoom1_rom_addr0: got cs=%b addr=%h, expected cs=1 addr=%h", rom_cs, rom_addr, {16'h1234, 4'h3, 1'b0}); end
        tick();
        checks++; if (rom_cs !== 1'b1 || rom_addr !== {16'h1234, 4'h3, 1'b1})
            begin errors++; $display("FAIL zoom1_rom_addr1: got cs=%b addr=%h, expected cs=1 addr=%h", rom_cs, rom_addr, {16'h1234, 4'h3, 1'b1}); end
        tick();
        checks++; if (rom_cs !== 1'b0 || buf_we !== 1'b0)
            begin errors++; $display("FAIL zoom1_fetch_done: got cs=%b we=%b, expected cs=0 we=0", rom_cs, buf_we); end
        tick();
        checks++; if (buf_we !== 1'b1 || buf_addr !== 9'h100 || buf_din[3:0] !== 4'h1)
            begin errors++; $display("FAIL zoom1_first_pixel: got we=%b addr=%h pen=%h, expected we=1 addr=100 pen=1", buf_we, buf_addr, buf_din[3:0]); end
        wait_idle(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL zoom1_busy_fall: got busy=%b, expected 0 within 100 cycles", dr_busy); end
        checks++; if (n_writes - n0 != 16) begin errors++; $display("FAIL zoom1_count: got %0d writes, expected 16", n_writes - n0); end
        checks++; if (buf_addr !== 9'h10F) begin errors++; $display("FAIL zoom1_last_addr: got %h, expected 10f", buf_addr); end
    endtask

    task automatic test_flip();
        int n0;
        bit ok;
        rom_w0 = 32'h12345678; rom_w1 = 32'h00000000;
        push_tile(10'h155, 1'b1, 9'h100, 10'd64, 1'b0);
        n0 = n_writes;
        start_tile(16'h1234, 10'h155, 1'b1, 1'b1, 9'h100, 4'd3, 10'd64, 1'b0);
        checks++; if (rom_addr !== {16'h1234, 4'hC, 1'b0})
            begin errors++; $display("FAIL flip_row: got addr=%h, expected %h", rom_addr, {16'h1234, 4'hC, 1'b0}); end
        wait_idle(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL flip_busy_fall: got busy=%b, expected 0", dr_busy); end
        checks++; if (n_writes - n0 != 8) begin errors++; $display("FAIL flip_count: got %0d writes, expected 8", n_writes - n0); end
        checks++; if (buf_addr !== 9'h10F || buf_din[3:0] !== 4'h1)
            begin errors++; $display("FAIL flip_last: got addr=%h pen=%h, expected addr=10f pen=1", buf_addr, buf_din[3:0]); end
    endtask

    task automatic test_enlarge_keep();
        int n0;
        bit ok;
        rom_w0 = 32'h12345678; rom_w1 = 32'h9ABCDEF1;
        push_tile(10'h0F0, 1'b0, 9'h1F8, 10'd32, 1'b0);
        n0 = n_writes;
        start_tile(16'h0042, 10'h0F0, 1'b0, 1'b0, 9'h1F8, 4'd0, 10'd32, 1'b0);
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL enlarge_busy_fall: got busy=%b, expected 0", dr_busy); end
        checks++; if (n_writes - n0 != 32) begin errors++; $display("FAIL enlarge_count: got %0d writes, expected 32", n_writes - n0); end
        checks++; if (buf_addr !== 9'h017) begin errors++; $display("FAIL enlarge_wrap_last: got %h, expected 017", buf_addr); end
        push_tile(10'h0F1, 1'b0, 9'h0AA, 10'd32, 1'b1);
        n0 = n_writes;
        start_tile(16'h0043, 10'h0F1, 1'b0, 1'b0, 9'h0AA, 4'd0, 10'd32, 1'b1);
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL keep_busy_fall: got busy=%b, expected 0", dr_busy); end
        checks++; if (n_writes - n0 != 32) begin errors++; $display("FAIL keep_count: got %0d writes, expected 32", n_writes - n0); end
        checks++; if (buf_addr !== 9'h037) begin errors++; $display("FAIL keep_last: got %h, expected 037", buf_addr); end
    endtask

    task automatic test_reduce();
        int n0;
        bit ok;
        rom_w0 = 32'h12345678; rom_w1 = 32'h9ABCDEF1;
        push_tile(10'h001, 1'b0, 9'h020, 10'd128, 1'b0);
        n0 = n_writes;
        start_tile(16'h0007, 10'h001, 1'b0, 1'b0, 9'h020, 4'd5, 10'd128, 1'b0);
        wait_idle(100, ok);
        checks++; if (!ok || n_writes - n0 != 8)
            begin errors++; $display("FAIL reduce_count: got %0d writes idle=%b, expected 8 idle=1", n_writes - n0, ok); end
        checks++; if (buf_addr !== 9'h027 || buf_din[3:0] !== 4'hF)
            begin errors++; $display("FAIL reduce_last: got addr=%h pen=%h, expected addr=027 pen=f", buf_addr, buf_din[3:0]); end
        push_tile(10'h002, 1'b0, 9'h040, 10'd0, 1'b0);
        n0 = n_writes;
        start_tile(16'h0007, 10'h002, 1'b0, 1'b0, 9'h040, 4'd5, 10'd0, 1'b0);
        wait_idle(100, ok);
        checks++; if (!ok || n_writes - n0 != 16)
            begin errors++; $display("FAIL zero_zoom_count: got %0d writes idle=%b, expected 16 idle=1", n_writes - n0, ok); end
        checks++; if (buf_addr !== 9'h04F) begin errors++; $display("FAIL zero_zoom_last: got %h, expected 04f", buf_addr); end
    endtask

    task automatic test_back_to_back();
        int n0;
        bit ok;
        bit seen;
        rom_w0 = 32'h12345678; rom_w1 = 32'h9ABCDEF1; rom_stall = 1'b1;
        push_tile(10'h333, 1'b0, 9'h040, 10'd64, 1'b0);
        n0 = n_writes;
        start_tile(16'hBEEF, 10'h333, 1'b0, 1'b0, 9'h040, 4'd9, 10'd64, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rom_cs !== 1'b1 || rom_addr !== {16'hBEEF, 4'h9, 1'b0} || buf_we !== 1'b0)
                begin errors++; $display("FAIL stall_hold: got cs=%b addr=%h we=%b, expected cs=1 addr=%h we=0", rom_cs, rom_addr, buf_we, {16'hBEEF, 4'h9, 1'b0}); end
            tick();
        end
        rom_stall = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (n_writes - n0 >= 2) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checks++; if (!seen) begin errors++; $display("FAIL stall_resume: got %0d writes, expected at least 2", n_writes - n0); end
        start_tile(16'h0101, 10'h3FF, 1'b1, 1'b0, 9'h080, 4'd1, 10'd64, 1'b0);
        wait_idle(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_busy_fall: got busy=%b, expected 0", dr_busy); end
        checks++; if (n_writes - n0 != 16) begin errors++; $display("FAIL b2b_count: got %0d writes, expected 16", n_writes - n0); end
        repeat (5) tick();
        checks++; if (dr_busy !== 1'b0 || rom_cs !== 1'b0)
            begin errors++; $display("FAIL b2b_ignored: got busy=%b cs=%b, expected busy=0 cs=0", dr_busy, rom_cs); end
    endtask

    task automatic test_reset_mid();
        int n0;
        bit seen;
        rom_w0 = 32'h12345678; rom_w1 = 32'h9ABCDEF1;
        push_tile(10'h0AA, 1'b0, 9'h100, 10'd64, 1'b0);
        n0 = n_writes;
        start_tile(16'h1234, 10'h0AA, 1'b0, 1'b0, 9'h100, 4'd3, 10'd64, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (n_writes - n0 >= 4) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checks++; if (!seen) begin errors++; $display("FAIL rstmid_reach4: got %0d writes, expected 4", n_writes - n0); end
        rst = 1'b1;
        q_addr.delete();
        q_din.delete();
        m_pos = 0;
        m_acc = 0;
        tick();
        rst = 1'b0;
        checks++; if (dr_busy !== 1'b0 || buf_we !== 1'b0)
            begin errors++; $display("FAIL rstmid_abort: got busy=%b we=%b, expected busy=0 we=0", dr_busy, buf_we); end
        repeat (30) tick();
        checks++; if (n_writes - n0 != 4) begin errors++; $display("FAIL rstmid_no_more: got %0d writes, expected 4", n_writes - n0); end
        checks++; if (dr_busy !== 1'b0 || rom_cs !== 1'b0)
            begin errors++; $display("FAIL rstmid_idle: got busy=%b cs=%b, expected busy=0 cs=0", dr_busy, rom_cs); end
    endtask

    task automatic test_queue_drained();
        checks++;
        if (q_addr.size() != 0) begin
            errors++;
            $display("FAIL missing_writes: got %0d writes outstanding, expected 0", q_addr.size());
        end
    endtask

    initial begin
        test_reset();
        test_zoom1();
        test_queue_drained();
        test_flip();
        test_queue_drained();
        test_enlarge_keep();
        test_queue_drained();
        test_reduce();
        test_queue_drained();
        test_back_to_back();
        test_queue_drained();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
